serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits (>= 2).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  operands presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  minuend.
REQ-008 The block SHALL have port b  input  WIDTH  subtrahend.
REQ-009 The block SHALL have port borrow_in  input  1  initial borrow into the LSB digit.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
REQ-013 The block SHALL have port borrow_out  output  1  unsigned borrow out of the MSB (1 = a < b + borrow_in).
REQ-014 The block SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-015 The block SHALL have port zero  output  1  diff == 0.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 In IDLE, in_ready SHALL be 1 and out_valid 0; all other states SHALL drive in_ready 0.
REQ-018 On in_valid & in_ready, the block SHALL capture a, b, borrow_in into internal shift registers, clear the digit counter and enter RUN; in_valid outside IDLE SHALL be ignored.
REQ-019 Each RUN cycle SHALL subtract the DIGIT least-significant bits of the a/b shift registers with the stored borrow, shift the DIGIT-bit result into the result register from the MSB end, update the borrow flop, and shift the operands right by DIGIT.
REQ-020 After N = WIDTH/DIGIT RUN cycles, the FSM SHALL enter DONE with out_valid = 1; the capturing edge plus N edges SHALL give out_valid high.
REQ-021 In DONE, diff, borrow_out, overflow and zero SHALL be held stable until out_valid & out_ready.
REQ-022 On out_valid & out_ready, the FSM SHALL return to IDLE at that edge; in_ready SHALL be 1 in the following cycle (no same-cycle accept).
REQ-023 overflow SHALL equal (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]) using captured operands.
REQ-024 borrow_out SHALL be the final borrow flop value.
REQ-025 The block SHALL set zero combinationally from the result register.
REQ-026 Result outputs SHALL be don't-care while out_valid = 0, and SHALL hold the last result in practice.

Reset
REQ-027 rst high SHALL force, asynchronously: FSM to IDLE, counter to 0, borrow flop to 0, result register to 0, out_valid 0, diff 0, borrow_out 0, overflow 0, zero 1.
REQ-028 rst asserted mid-RUN or in DONE SHALL abandon the operation with no result emitted; the first accept after rst deasserts SHALL start a clean operation.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration (IDLE/RUN/DONE) and a width-of-counter helper constant function.
REQ-030 One sub-module, sub_digit (parameter DIGIT; inputs x, y, bin; outputs d, bout; combinational ripple of bit-level subtract cells), SHALL perform the per-cycle digit subtraction.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=0x05, b=0x03, borrow_in=0 -> after 8 cycles diff=0x02, borrow_out=0, overflow=0, zero=0.
REQ-032 WIDTH=8, DIGIT=1: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0; a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
REQ-033 WIDTH=8, DIGIT=4: a=0x00, b=0x00, borrow_in=1 -> out_valid 2 edges after accept, diff=0xFF, borrow_out=1; a=b=0x5A, borrow_in=0 -> zero=1.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; second in_valid during RUN is not accepted.
REQ-035 rst pulsed in RUN cycle 3 -> out_valid never rises for that operation; the next operation (0x10-0x01) returns 0x0F.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_subtractor_pkg
// Brief    : Shared FSM state encoding and counter sizing helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_sub_digit.sv
//------------------------------------------------------------------------------
// Module   : sub_digit
// Brief    : Combinational DIGIT-bit ripple-borrow subtractor, d = x - y - bin.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] w_b;

    assign w_b[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign d[i]     = x[i] ^ y[i] ^ w_b[i];
        assign w_b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b[i]);
    end

    assign bout = w_b[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : serial_subtractor
// Brief    : Digit-serial a - b - borrow_in with valid/ready handshakes and
//            borrow, signed-overflow and zero flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int              c_n    = WIDTH / DIGIT;
    localparam int              c_cw   = cnt_width(c_n);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_step;
    logic              w_in_ready;
    logic              w_out_valid;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_borrow;
    logic [c_cw-1:0]   r_cnt;
    logic              r_a_msb;
    logic              r_b_msb;

    logic [DIGIT-1:0]  w_d;
    logic              w_bout;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  w_b_next;
    logic [WIDTH-1:0]  w_res_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .x    (r_a[DIGIT-1:0]),
        .y    (r_b[DIGIT-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result digits enter at the MSB end so the LSB digit lands at bit 0 last.
    if (DIGIT == WIDTH) begin : g_single
        assign w_res_next = w_d;
        assign w_a_next   = '0;
        assign w_b_next   = '0;
    end else begin : g_multi
        assign w_res_next = {w_d, r_res[WIDTH-1:DIGIT]};
        assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
        assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= borrow_in;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (w_step) begin
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_res    <= w_res_next;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + c_cw'(1);
        end
    end

    // Sign bits are kept separately because the operand registers are consumed.
    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign diff       = r_res;
    assign borrow_out = r_borrow;
    assign overflow   = (r_a_msb ^ r_b_msb) & (r_res[WIDTH-1] ^ r_a_msb);
    assign zero       = (r_res == '0);

endmodule

`default_nettype wire
